// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared types and constants for the write-back port arbiter that
//            merges pipeline WB writes and buffered muldiv results onto a
//            single register-file write port.
// Contents : arb_state_t   - arbiter FSM state encoding
//            md_entry_t    - muldiv FIFO entry {valid, rd, data}
//            c_FIFO_DEPTH  - muldiv buffer depth (fixed at 2)
//            c_STARVE_LIMIT- default head-age limit before a stall request
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

   localparam int c_FIFO_DEPTH   = 2;
   localparam int c_STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // no valid buffered result
      ST_WAIT  = 2'd1,   // valid head, counting cycles it loses arbitration
      ST_STALL = 2'd2    // head starved, pipeline asked to bubble WB
   } arb_state_t;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic [31:0] data;
   } md_entry_t;

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_md_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_md_fifo
// Purpose  : Two-entry muldiv result buffer. Slot 0 is always the head.
//            Entries can be invalidated in place by destination register
//            (stale kill); an invalidated entry still occupies its slot until
//            it is popped, so occupancy (count) and validity are tracked
//            separately.
// Ports    : clk, reset          - clock, async active-low reset
//            push/push_rd/_data  - enqueue a valid entry at the tail
//            pop                 - remove the head entry
//            kill_en/kill_rd     - invalidate resident entries with rd==kill_rd
//            head                - current head entry
//            count               - occupied slots (registered)
//            any_valid           - at least one resident entry is valid
//            any_valid_next      - same, as it will be after this edge
// Revision : 1.0 - initial release
// ============================================================================
module wb_md_fifo
   import wb_arb_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic [4:0]  push_rd,
   input  logic [31:0] push_data,
   input  logic        pop,
   input  logic        kill_en,
   input  logic [4:0]  kill_rd,
   output md_entry_t   head,
   output logic [1:0]  count,
   output logic        any_valid,
   output logic        any_valid_next
);

   md_entry_t   r_slot [2];
   logic [1:0]  r_count;

   logic [1:0]  w_kill_hit;
   md_entry_t   w_killed [2];
   md_entry_t   w_next [2];
   logic [1:0]  w_cnt_after_pop;
   logic [1:0]  w_count_next;

   // Kill compares only against entries already resident; a same-edge push
   // is written after the kill is applied, so it survives.
   for (genvar gi = 0; gi < 2; gi++) begin : g_kill
      assign w_kill_hit[gi] = kill_en && r_slot[gi].valid && (r_slot[gi].rd == kill_rd);
   end

   always_comb begin
      w_killed[0]       = r_slot[0];
      w_killed[1]       = r_slot[1];
      w_killed[0].valid = r_slot[0].valid & ~w_kill_hit[0];
      w_killed[1].valid = r_slot[1].valid & ~w_kill_hit[1];

      w_cnt_after_pop = r_count;
      w_next[0]       = w_killed[0];
      w_next[1]       = w_killed[1];
      if (pop && (r_count != 2'd0)) begin
         w_next[0]       = w_killed[1];
         w_next[1]       = '0;
         w_cnt_after_pop = r_count - 2'd1;
      end

      w_count_next = w_cnt_after_pop;
      if (push && (w_cnt_after_pop < 2'd2)) begin
         if (w_cnt_after_pop == 2'd0) begin
            w_next[0] = '{valid: 1'b1, rd: push_rd, data: push_data};
         end else begin
            w_next[1] = '{valid: 1'b1, rd: push_rd, data: push_data};
         end
         w_count_next = w_cnt_after_pop + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_slot[0] <= '0;
         r_slot[1] <= '0;
         r_count   <= 2'd0;
      end else begin
         r_slot[0] <= w_next[0];
         r_slot[1] <= w_next[1];
         r_count   <= w_count_next;
      end
   end

   assign head           = r_slot[0];
   assign count          = r_count;
   assign any_valid      = r_slot[0].valid | r_slot[1].valid;
   assign any_valid_next = w_next[0].valid | w_next[1].valid;

endmodule : wb_md_fifo
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Arbitrates the single register-file write port between the
//            pipeline WB stage (always preferred) and buffered muldiv results.
//            A muldiv head that keeps losing arbitration for STARVE_LIMIT
//            cycles raises stall_req so the pipeline bubbles WB and lets the
//            buffer drain. Pipeline writes kill older buffered results to the
//            same register so a stale value never overwrites a newer one.
// Ports    : clk, reset                  - clock, async active-low reset
//            wb_rf_en/wb_rd/wb_data      - pipeline WB write request
//            md_valid/md_rd/md_data      - muldiv result offer
//            md_ready                    - buffer has a free slot
//            rf_we/rf_waddr/rf_wdata     - registered RF write port
//            stall_req                   - registered pipeline freeze request
//            md_pending                  - buffer holds a valid result
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = c_STARVE_LIMIT,
   parameter int FIFO_DEPTH   = c_FIFO_DEPTH    // buffer is built for 2 only
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_rf_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        md_valid,
   input  logic [4:0]  md_rd,
   input  logic [31:0] md_data,
   output logic        md_ready,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        stall_req,
   output logic        md_pending
);

   localparam int               c_AGE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [c_AGE_W-1:0] c_LIMIT = c_AGE_W'(STARVE_LIMIT);
   localparam logic [1:0]       c_DEPTH = 2'(FIFO_DEPTH);

   arb_state_t          r_state;
   arb_state_t          w_state_next;
   logic [c_AGE_W-1:0]  r_age;
   logic [c_AGE_W-1:0]  w_age_next;
   logic [c_AGE_W-1:0]  w_age_inc;

   logic                r_rf_we;
   logic [4:0]          r_rf_waddr;
   logic [31:0]         r_rf_wdata;

   md_entry_t           w_head;
   logic [1:0]          w_count;
   logic                w_any_valid;
   logic                w_any_valid_next;

   logic                w_pipe_req;
   logic                w_push;
   logic                w_pop;
   logic                w_md_write;

   // Writes to r0 are architecturally void, so they never claim the port.
   assign w_pipe_req = wb_rf_en && (wb_rd != 5'd0);

   // Ready uses only the registered count; a same-edge pop does not open a
   // slot early. Forced low while reset is held.
   assign md_ready   = reset && (w_count < c_DEPTH);

   // r0-destined results are handshaken but dropped instead of buffered.
   assign w_push     = md_valid && md_ready && (md_rd != 5'd0);

   // Any idle port cycle retires the head: written if valid, silently
   // dropped if it was killed.
   assign w_pop      = !w_pipe_req && (w_count != 2'd0);
   assign w_md_write = w_pop && w_head.valid;

   wb_md_fifo u_fifo (
      .clk            (clk),
      .reset          (reset),
      .push           (w_push),
      .push_rd        (md_rd),
      .push_data      (md_data),
      .pop            (w_pop),
      .kill_en        (w_pipe_req),
      .kill_rd        (wb_rd),
      .head           (w_head),
      .count          (w_count),
      .any_valid      (w_any_valid),
      .any_valid_next (w_any_valid_next)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_age   <= '0;
      end else begin
         r_state <= w_state_next;
         r_age   <= w_age_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_age_next   = r_age;
      w_age_inc    = (r_age == c_LIMIT) ? r_age : r_age + 1'b1;

      case (r_state)
         ST_IDLE: begin
            if (w_any_valid_next) begin
               w_state_next = ST_WAIT;
               w_age_next   = '0;
            end
         end
         ST_WAIT: begin
            if (!w_any_valid_next) begin
               w_state_next = ST_IDLE;
               w_age_next   = '0;
            end else if (w_pop) begin
               w_age_next   = '0;
            end else begin
               w_age_next   = w_age_inc;
               if (w_age_inc == c_LIMIT) begin
                  w_state_next = ST_STALL;
               end
            end
         end
         ST_STALL: begin
            if (!w_any_valid_next) begin
               w_state_next = ST_IDLE;
               w_age_next   = '0;
            end else if (w_pop) begin
               w_state_next = ST_WAIT;
               w_age_next   = '0;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_age_next   = '0;
         end
      endcase
   end

   // ------------------------------------------------------- RF write port
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= 5'd0;
         r_rf_wdata <= 32'd0;
      end else if (w_pipe_req) begin
         r_rf_we    <= 1'b1;
         r_rf_waddr <= wb_rd;
         r_rf_wdata <= wb_data;
      end else if (w_md_write) begin
         r_rf_we    <= 1'b1;
         r_rf_waddr <= w_head.rd;
         r_rf_wdata <= w_head.data;
      end else begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= 5'd0;
         r_rf_wdata <= 32'd0;
      end
   end

   assign rf_we      = r_rf_we;
   assign rf_waddr   = r_rf_waddr;
   assign rf_wdata   = r_rf_wdata;
   assign stall_req  = (r_state == ST_STALL);
   assign md_pending = w_any_valid;

endmodule : wb_port_arbiter
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Directed self-checking bench for wb_port_arbiter. Expected RF
//            writes are queued as stimulus is driven and consumed by a
//            negedge monitor whenever rf_we is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_rf_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        md_valid;
   logic [4:0]  md_rd;
   logic [31:0] md_data;
   logic        md_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        stall_req;
   logic        md_pending;

   always #5 clk = ~clk;

   wb_port_arbiter #(
      .STARVE_LIMIT (4),
      .FIFO_DEPTH   (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wb_rf_en   (wb_rf_en),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .md_valid   (md_valid),
      .md_rd      (md_rd),
      .md_data    (md_data),
      .md_ready   (md_ready),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .stall_req  (stall_req),
      .md_pending (md_pending)
   );

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];
   wr_t mon_e;
   int  n_checks = 0;
   int  n_pass   = 0;
   int  n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every observed RF write must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset === 1'b1 && rf_we === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 64'(rf_we), 64'h0);
         end else begin
            mon_e = sb.pop_front();
            check("rf_write", 64'({rf_waddr, rf_wdata}), 64'({mon_e.rd, mon_e.data}));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b0;
      wb_rf_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
      md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
      #1;
      check("rst_rf_we",      64'(rf_we),      64'h0);
      check("rst_md_ready",   64'(md_ready),   64'h0);
      check("rst_stall",      64'(stall_req),  64'h0);
      check("rst_md_pending", 64'(md_pending), 64'h0);
      tick(); tick();
      reset = 1'b1;
      tick();
      check("post_rst_md_ready", 64'(md_ready), 64'h1);

      // ---- pipeline only
      wb_rf_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
      sb.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
      tick();
      check("pipe_we",   64'(rf_we),    64'h1);
      check("pipe_addr", 64'(rf_waddr), 64'h5);
      check("pipe_data", 64'(rf_wdata), 64'hDEADBEEF);
      wb_rd = 5'd0; wb_data = 32'h11111111;
      tick();
      check("pipe_r0_no_we", 64'(rf_we), 64'h0);
      wb_rf_en = 1'b0;
      tick();

      // ---- muldiv idle path: accepted at N, written after N+1
      md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h12345678;
      check("md_ready_idle", 64'(md_ready), 64'h1);
      tick();
      md_valid = 1'b0;
      check("md_pending_after_accept", 64'(md_pending), 64'h1);
      check("md_no_bypass",            64'(rf_we),      64'h0);
      sb.push_back('{rd: 5'd9, data: 32'h12345678});
      tick();
      check("md_we",         64'(rf_we),      64'h1);
      check("md_addr",       64'(rf_waddr),   64'h9);
      check("md_pending_clr",64'(md_pending), 64'h0);
      tick();

      // ---- muldiv result to r0 is accepted and dropped
      md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h0BAD0BAD;
      tick();
      md_valid = 1'b0;
      check("md_r0_not_pending", 64'(md_pending), 64'h0);
      tick();
      check("md_r0_no_we", 64'(rf_we), 64'h0);

      // ---- stale kill: buffered r6 superseded by a later pipeline write
      md_valid = 1'b1; md_rd = 5'd6; md_data = 32'h0000AAAA;
      wb_rf_en = 1'b1; wb_rd = 5'd10; wb_data = 32'h00001010;
      sb.push_back('{rd: 5'd10, data: 32'h00001010});
      tick();
      md_valid = 1'b0;
      check("kill_pending_before", 64'(md_pending), 64'h1);
      wb_rd = 5'd6; wb_data = 32'h0000BBBB;
      sb.push_back('{rd: 5'd6, data: 32'h0000BBBB});
      tick();
      check("kill_pending_after", 64'(md_pending), 64'h0);
      wb_rf_en = 1'b0;
      tick();
      check("kill_drop_no_we", 64'(rf_we),    64'h0);
      check("kill_slot_freed", 64'(md_ready), 64'h1);
      tick();

      // ---- same-edge accept and pipeline write to same rd: entry survives
      md_valid = 1'b1; md_rd = 5'd6; md_data = 32'h0000CCCC;
      wb_rf_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h0000DDDD;
      sb.push_back('{rd: 5'd6, data: 32'h0000DDDD});
      tick();
      md_valid = 1'b0; wb_rf_en = 1'b0;
      check("sameedge_kept", 64'(md_pending), 64'h1);
      sb.push_back('{rd: 5'd6, data: 32'h0000CCCC});
      tick();
      check("sameedge_data", 64'(rf_wdata), 64'h0000CCCC);
      tick();

      // ---- starvation: buffer rd3, rd4 while pipeline writes rd7 each cycle
      wb_rf_en = 1'b1; wb_rd = 5'd7;
      for (int i = 0; i < 5; i++) begin
         md_valid = (i < 2);
         md_rd    = 5'(3 + i);
         md_data  = 32'h00000033 + 32'(i) * 32'h11;
         wb_data  = 32'h70000000 + 32'(i);
         sb.push_back('{rd: 5'd7, data: 32'h70000000 + 32'(i)});
         tick();
         if (i == 1) check("starve_full_md_ready", 64'(md_ready), 64'h0);
         if (i == 3) check("starve_not_yet",       64'(stall_req), 64'h0);
      end
      md_valid = 1'b0;
      check("starve_stall", 64'(stall_req), 64'h1);
      check("starve_md_ready", 64'(md_ready), 64'h0);

      // Bubble WB; offer rd12 against a full buffer (must be held off).
      wb_rf_en = 1'b0;
      md_valid = 1'b1; md_rd = 5'd12; md_data = 32'h00000C12;
      check("full_holdoff", 64'(md_ready), 64'h0);
      sb.push_back('{rd: 5'd3, data: 32'h00000033});
      tick();
      check("bubble_stall_drop", 64'(stall_req), 64'h0);
      check("bubble_first_rd3",  64'(rf_waddr),  64'h3);
      check("bubble_md_ready",   64'(md_ready),  64'h1);
      sb.push_back('{rd: 5'd4, data: 32'h00000044});
      tick();
      md_valid = 1'b0;
      check("bubble_second_rd4",     64'(rf_waddr),   64'h4);
      check("pushpop_pending",       64'(md_pending), 64'h1);
      check("pushpop_md_ready",      64'(md_ready),   64'h1);
      sb.push_back('{rd: 5'd12, data: 32'h00000C12});
      tick();
      check("held_entry_written", 64'(rf_wdata),   64'h00000C12);
      check("drained_pending",    64'(md_pending), 64'h0);
      tick();

      // ---- reset in the middle of a stall
      wb_rf_en = 1'b1; wb_rd = 5'd7;
      for (int i = 0; i < 5; i++) begin
         md_valid = (i < 2);
         md_rd    = 5'(3 + i);
         md_data  = 32'h0000E000 + 32'(i);
         wb_data  = 32'h7A000000 + 32'(i);
         sb.push_back('{rd: 5'd7, data: 32'h7A000000 + 32'(i)});
         tick();
      end
      md_valid = 1'b0;
      check("pre_reset_stall", 64'(stall_req), 64'h1);
      #2;
      reset    = 1'b0;
      wb_rf_en = 1'b0;
      sb.delete();
      #1;
      check("rst_mid_we",      64'(rf_we),      64'h0);
      check("rst_mid_addr",    64'(rf_waddr),   64'h0);
      check("rst_mid_data",    64'(rf_wdata),   64'h0);
      check("rst_mid_stall",   64'(stall_req),  64'h0);
      check("rst_mid_pending", 64'(md_pending), 64'h0);
      check("rst_mid_ready",   64'(md_ready),   64'h0);
      tick(); tick();
      reset = 1'b1;
      tick();
      check("post_rst2_ready",   64'(md_ready),   64'h1);
      check("post_rst2_pending", 64'(md_pending), 64'h0);
      for (int i = 0; i < 4; i++) tick();
      check("post_rst2_stall", 64'(stall_req), 64'h0);
      check("sb_drained",      64'(sb.size()), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_wb_port_arbiter
`default_nettype wire
